sha256_chunk_processor: RTL and testbench
=========================================

// Module: sha256_chunk_processor
// PURPOSE
//  Consumes 512-bit padded chunks from the upstream preprocessor and runs the SHA-256 compression function on each.
//  Default rate is one round per cycle.
//  Keeps the running hash H0..H7 across the chunks of one message.
//  Presents the 256-bit digest after the chunk flagged last, then reloads the IV for the next message.
// PARAMETERS
//  ROUNDS    64   compression rounds per chunk (fixed by SHA-256; must not be overridden)
//  H_INIT    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19   IV, H0 in MSBs
// PORTS
//  clk                    in   1    single clock, all logic on posedge
//  reset                  in   1    synchronous, active-high
//  chunk                  in   512  message block; word W[i] = chunk[32*i +: 32], i=0..15
//  chunk_valid            in   1    chunk is presented and stable
//  chunk_last             in   1    qualifies chunk: final chunk of the message
//  chunk_processor_ready  out  1    block can accept a chunk this cycle
//  digest                 out  256  final hash, H0 in [255:224] ... H7 in [31:0]
//  digest_valid           out  1    one-cycle pulse: digest is valid
//  busy                   out  1    compression in progress
// BEHAVIOUR
//  Reset values:
//   - state=IDLE, H=H_INIT, round counter t=0.
//   - chunk_processor_ready=1, digest=0, digest_valid=0, busy=0.
//   - Reset wins over every other event, including mid-compression; the partial hash is discarded and H returns to H_INIT.
//  Handshake:
//   - A transfer occurs on a posedge with chunk_valid && chunk_processor_ready.
//   - chunk_processor_ready is 1 only in IDLE. It is a registered function of state, with no combinational path from chunk_valid.
//   - chunk_valid while not ready is ignored; upstream holds the chunk.
//  FSM:
//   - IDLE: on transfer, latch W[0..15] into a 16x32 schedule shift register, latch chunk_last, load a..h <= H, t <= 0, go to ROUND.
//   - ROUND: one round per cycle.
//     - Wt = W[0] for all t; shift in the new word W16 = s1(W[14]) + W[9] + s0(W[1]) + W[0].
//     - T1 = h + S1(e) + Ch(e,f,g) + K[t] + Wt; T2 = S0(a) + Maj(a,b,c).
//     - Standard a..h update; t++.
//     - After t=63, go to UPDATE.
//   - UPDATE (1 cycle): Hi <= Hi + var_i for each of the 8 words, all mod 2^32.
//     - last=1: digest <= new H, digest_valid=1 for exactly this next cycle, H <= H_INIT.
//     - last=0: H retained.
//     - Always return to IDLE.
//  Latency: transfer at edge T; ready high again and digest_valid high in cycle T+66 (64 ROUND + 1 UPDATE).
//   - A back-to-back chunk is accepted at edge T+66.
//  Arithmetic:
//   - All adds are 32-bit and wrap; carries are dropped.
//   - K[0..63] is a constant ROM indexed by t[5:0].
//   - S0 = ror2^ror13^ror22; S1 = ror6^ror11^ror25; s0 = ror7^ror18^shr3; s1 = ror17^ror19^shr10.
//  Boundaries:
//   - digest holds its value until the next UPDATE with last=1, including across new messages.
//   - busy=1 in ROUND and UPDATE.
//   - chunk_last is sampled only at the transfer.
// CONFIGURATION
//  SHA256_UNROLL2_EN defined:
//   - Two rounds per cycle, using two combinational round stages and two schedule words per cycle.
//   - t steps by 2; ROUND lasts 32 cycles.
//   - Latency: ready and digest_valid high in cycle T+34.
//  Not defined: one round per cycle, latency T+66 as above.
//  Digest values are identical in both builds.
// TESTING
//  1. Single chunk "abc": W0=32'h61626380, W1..W14=0, W15=32'h18, last=1.
//     -> digest = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, pulse at T+66 (T+34 with UNROLL2).
//  2. Empty message: W0=32'h80000000, others 0, last=1.
//     -> digest = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
//  3. Two chunks of the 448-bit "abcdbcde...nopq": chunk 1 last=0, chunk 2 last=1.
//     -> no pulse after chunk 1; after chunk 2, digest = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
//  4. Hold chunk_valid=1 throughout a compression.
//     -> ready=0 for 65 cycles; exactly one transfer per chunk; no double-accept.
//  5. Assert reset at round 30 of "abc", then resend "abc".
//     -> no digest_valid from the aborted run; correct "abc" digest after the resend (H was reloaded with the IV).
//  6. Back-to-back "abc" then empty message, chunk_valid held high.
//     -> two pulses 66 cycles apart with digests from scenario 1 then scenario 2.

Source files
------------

// File: rtl/sha256_chunk_processor.sv
// SHA-256 compression over 512-bit chunks, keeping the running hash across a message.
// Define SHA256_UNROLL2_EN to run two rounds per cycle instead of one.
module sha256_chunk_processor #(
  parameter int           ROUNDS = 64,
  parameter logic [255:0] H_INIT = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [511:0] chunk,
  input  logic         chunk_valid,
  input  logic         chunk_last,
  output logic         chunk_processor_ready,
  output logic [255:0] digest,
  output logic         digest_valid,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, ROUND, UPDATE} state_t;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_s0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_s1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Working variables are packed a..h with a in the MSBs, matching the H layout.
  function automatic logic [255:0] round_step(input logic [255:0] v, input logic [31:0] k,
                                              input logic [31:0] wt);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    {a, b, c, d, e, f, g, h} = v;
    t1 = h + big_s1(e) + ((e & f) ^ (~e & g)) + k + wt;
    t2 = big_s0(a) + ((a & b) ^ (a & c) ^ (b & c));
    return {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

  state_t         state, next_state;
  logic [255:0]   h_state, vars, vars_next, h_sum;
  logic [31:0]    w [16];
  logic [5:0]     t;
  logic           last_chunk;
  logic           transfer, last_round;

  assign transfer = chunk_valid && chunk_processor_ready;
  assign busy     = (state != IDLE);

`ifdef SHA256_UNROLL2_EN
  localparam logic [5:0] T_LAST = 6'(ROUNDS - 2);
  localparam logic [5:0] T_STEP = 6'd2;
  logic [31:0] w16, w17;

  // w17 only needs W[15], so both new schedule words come straight from the register.
  assign w16       = small_s1(w[14]) + w[9] + small_s0(w[1]) + w[0];
  assign w17       = small_s1(w[15]) + w[10] + small_s0(w[2]) + w[1];
  assign vars_next = round_step(round_step(vars, K[t], w[0]), K[t + 6'd1], w[1]);
`else
  localparam logic [5:0] T_LAST = 6'(ROUNDS - 1);
  localparam logic [5:0] T_STEP = 6'd1;
  logic [31:0] w16;

  assign w16       = small_s1(w[14]) + w[9] + small_s0(w[1]) + w[0];
  assign vars_next = round_step(vars, K[t], w[0]);
`endif

  assign last_round = (t == T_LAST);

  always_comb begin
    h_sum = '0;
    for (int i = 0; i < 8; i++) begin
      h_sum[32*i +: 32] = h_state[32*i +: 32] + vars[32*i +: 32];
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (transfer) next_state = ROUND;
      ROUND:   if (last_round) next_state = UPDATE;
      UPDATE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state                 <= IDLE;
      h_state               <= H_INIT;
      vars                  <= '0;
      t                     <= '0;
      last_chunk            <= 1'b0;
      chunk_processor_ready <= 1'b1;
      digest                <= '0;
      digest_valid          <= 1'b0;
      for (int i = 0; i < 16; i++) w[i] <= '0;
    end else begin
      state                 <= next_state;
      chunk_processor_ready <= (next_state == IDLE);
      digest_valid          <= 1'b0;
      case (state)
        IDLE: begin
          if (transfer) begin
            for (int i = 0; i < 16; i++) w[i] <= chunk[32*i +: 32];
            last_chunk <= chunk_last;
            vars       <= h_state;
            t          <= '0;
          end
        end
        ROUND: begin
          vars <= vars_next;
          t    <= t + T_STEP;
`ifdef SHA256_UNROLL2_EN
          for (int i = 0; i < 14; i++) w[i] <= w[i+2];
          w[14] <= w16;
          w[15] <= w17;
`else
          for (int i = 0; i < 15; i++) w[i] <= w[i+1];
          w[15] <= w16;
`endif
        end
        UPDATE: begin
          // The final chunk publishes the digest and rearms the IV for the next message.
          if (last_chunk) begin
            digest       <= h_sum;
            digest_valid <= 1'b1;
            h_state      <= H_INIT;
          end else begin
            h_state <= h_sum;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_chunk_processor.sv
// Scoreboard bench for sha256_chunk_processor: directed known-answer chunks, latency and handshake checks.
// Honours SHA256_UNROLL2_EN for the expected latency.
module tb_sha256_chunk_processor;

`ifdef SHA256_UNROLL2_EN
  localparam int LAT = 33;
`else
  localparam int LAT = 65;
`endif

  localparam logic [255:0] ABC_DIGEST   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] EMPTY_DIGEST = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] TWO_DIGEST   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  logic         clk = 1'b0;
  logic         reset;
  logic [511:0] chunk;
  logic         chunk_valid;
  logic         chunk_last;
  logic         chunk_processor_ready;
  logic [255:0] digest;
  logic         digest_valid;
  logic         busy;

  typedef struct {
    logic [255:0] digest;
    int           cycle;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  int           cyc = 0;
  int           checks = 0;
  int           fails = 0;
  int           xfers = 0;
  logic [511:0] abc_chunk, empty_chunk, two_c1, two_c2;
  logic [31:0]  wv [16];

  always #5 clk = ~clk;

  sha256_chunk_processor dut (
    .clk                   (clk),
    .reset                 (reset),
    .chunk                 (chunk),
    .chunk_valid           (chunk_valid),
    .chunk_last            (chunk_last),
    .chunk_processor_ready (chunk_processor_ready),
    .digest                (digest),
    .digest_valid          (digest_valid),
    .busy                  (busy)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (!reset && chunk_valid && chunk_processor_ready) xfers <= xfers + 1;
  end

  function automatic logic [511:0] pack16(input logic [31:0] w [16]);
    logic [511:0] c;
    for (int i = 0; i < 16; i++) c[32*i +: 32] = w[i];
    return c;
  endfunction

  task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
    end
  endtask

  // Monitor: every digest pulse must match the oldest outstanding expectation, on the expected cycle.
  always @(negedge clk) begin
    if (!reset && digest_valid) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_pulse", 256'(1), 256'(0));
      end else begin
        mon_e = sb.pop_front();
        checkOutput("digest", digest, mon_e.digest);
        checkOutput("pulse_cycle", 256'(cyc), 256'(mon_e.cycle));
      end
    end
  end

  // Called at a negedge; returns at the negedge where ready has come back high.
  task automatic applyStimulus(input logic [511:0] c, input logic l, input logic expect_pulse,
                               input logic [255:0] exp_digest, input logic hold_valid);
    int budget;
    int low;
    chunk       = c;
    chunk_last  = l;
    chunk_valid = 1'b1;
    budget = 0;
    while (!chunk_processor_ready && budget < 500) begin
      @(negedge clk);
      budget++;
    end
    if (!chunk_processor_ready) begin
      checkOutput("accept_timeout", 256'(0), 256'(1));
      chunk_valid = 1'b0;
      return;
    end
    if (expect_pulse) sb.push_back('{exp_digest, cyc + 1 + LAT});
    @(posedge clk);
    @(negedge clk);
    checkOutput("busy_after_accept", 256'(busy), 256'(1));
    if (!hold_valid) chunk_valid = 1'b0;
    low = 0;
    while (!chunk_processor_ready && low < 500) begin
      low++;
      @(negedge clk);
    end
    checkOutput("ready_low_cycles", 256'(low), 256'(LAT));
  endtask

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset       = 1'b1;
    chunk       = '0;
    chunk_valid = 1'b0;
    chunk_last  = 1'b0;

    for (int i = 0; i < 16; i++) wv[i] = '0;
    wv[0] = 32'h61626380; wv[15] = 32'h00000018;
    abc_chunk = pack16(wv);
    for (int i = 0; i < 16; i++) wv[i] = '0;
    wv[0] = 32'h80000000;
    empty_chunk = pack16(wv);
    wv = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869,
           32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
           32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    two_c1 = pack16(wv);
    for (int i = 0; i < 16; i++) wv[i] = '0;
    wv[15] = 32'h000001c0;
    two_c2 = pack16(wv);

    repeat (3) @(negedge clk);
    reset = 1'b0;
    checkOutput("reset_ready", 256'(chunk_processor_ready), 256'(1));
    checkOutput("reset_digest", digest, 256'(0));
    checkOutput("reset_digest_valid", 256'(digest_valid), 256'(0));
    checkOutput("reset_busy", 256'(busy), 256'(0));

    $display("[TB] single chunk abc");
    applyStimulus(abc_chunk, 1'b1, 1'b1, ABC_DIGEST, 1'b0);
    @(negedge clk);
    checkOutput("pulse_width", 256'(digest_valid), 256'(0));
    checkOutput("digest_hold", digest, ABC_DIGEST);

    $display("[TB] empty message");
    applyStimulus(empty_chunk, 1'b1, 1'b1, EMPTY_DIGEST, 1'b0);

    $display("[TB] two-chunk message");
    applyStimulus(two_c1, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("digest_hold_nonlast", digest, EMPTY_DIGEST);
    applyStimulus(two_c2, 1'b1, 1'b1, TWO_DIGEST, 1'b0);

    $display("[TB] valid held through compression");
    applyStimulus(abc_chunk, 1'b1, 1'b1, ABC_DIGEST, 1'b1);
    chunk_valid = 1'b0;

    $display("[TB] reset mid-compression");
    @(negedge clk);
    chunk       = abc_chunk;
    chunk_last  = 1'b1;
    chunk_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chunk_valid = 1'b0;
    repeat (29) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort_ready", 256'(chunk_processor_ready), 256'(1));
    checkOutput("abort_busy", 256'(busy), 256'(0));
    checkOutput("abort_digest", digest, 256'(0));
    applyStimulus(abc_chunk, 1'b1, 1'b1, ABC_DIGEST, 1'b0);

    $display("[TB] back-to-back messages");
    applyStimulus(abc_chunk, 1'b1, 1'b1, ABC_DIGEST, 1'b1);
    applyStimulus(empty_chunk, 1'b1, 1'b1, EMPTY_DIGEST, 1'b1);
    chunk_valid = 1'b0;

    repeat (5) @(negedge clk);
    checkOutput("pending_expected", 256'(sb.size()), 256'(0));
    checkOutput("transfer_count", 256'(xfers), 256'(9));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
